key_loader_mux4: RTL and testbench

KEY_LOADER_MUX4 -- requirements
Module: key_loader_mux4

---
 rtl/key_loader_pkg.sv | 15 +
 rtl/key_parity_chk.sv | 11 +
 rtl/key_loader_mux4.sv | 131 +++++++++++++
 tb/tb_key_loader_mux4.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/key_loader_pkg.sv
// Shared types and defaults for the serial key loader feeding the
// mux4-locked c432 key inputs.
package key_loader_pkg;

    localparam int KEY_W_DEF    = 4;
    localparam int MAX_FAIL_DEF = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

endpackage

// File: rtl/key_parity_chk.sv
// Even-parity check over one received key frame (key bits plus parity).
module key_parity_chk #(
    parameter int W = 5
) (
    input  logic [W-1:0] frame,
    output logic         ok
);

    assign ok = ~(^frame);

endmodule

// File: rtl/key_loader_mux4.sv
// Serial key loader: shifts in a parity-protected frame and commits the
// key to p1..p4 only after a good check; repeated failures lock it out.
module key_loader_mux4
    import key_loader_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int MAX_FAIL = MAX_FAIL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_sin,
    input  logic key_valid,
    input  logic abort,
    output logic p1,
    output logic p2,
    output logic p3,
    output logic p4,
    output logic key_ready,
    output logic load_err,
    output logic locked_out,
    output logic busy
);

    localparam int CW = $clog2(KEY_W + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [FW-1:0]    fails;
    logic [FW-1:0]    fails_inc;
    logic [KEY_W:0]   sr;
    logic [KEY_W-1:0] key;
    logic             ready_q;
    logic             err_q;
    logic             lock_q;
    logic             busy_q;
    logic             parity_ok;

    key_parity_chk #(
        .W (KEY_W + 1)
    ) u_par (
        .frame (sr),
        .ok    (parity_ok)
    );

    // Saturating so the counter can never wrap back below the threshold.
    always_comb begin
        fails_inc = fails;
        if (fails != FW'(MAX_FAIL)) begin
            fails_inc = fails + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            fails   <= '0;
            sr      <= '0;
            key     <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        sr      <= {{KEY_W{1'b0}}, key_sin};
                        cnt     <= CW'(1);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (key_valid) begin
                        sr[cnt] <= key_sin;
                        if (cnt == CW'(KEY_W)) begin
                            state <= CHECK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    cnt    <= '0;
                    busy_q <= 1'b0;
                    if (parity_ok) begin
                        key     <= sr[KEY_W-1:0];
                        ready_q <= 1'b1;
                        fails   <= '0;
                        state   <= IDLE;
                    end else begin
                        err_q   <= 1'b1;
                        ready_q <= 1'b0;
                        fails   <= fails_inc;
                        if (fails_inc == FW'(MAX_FAIL)) begin
                            key    <= '0;
                            lock_q <= 1'b1;
                            state  <= LOCKOUT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    state <= LOCKOUT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign p1         = key[0];
    assign p2         = key[1];
    assign p3         = key[2];
    assign p4         = key[3];
    assign key_ready  = ready_q;
    assign load_err   = err_q;
    assign locked_out = lock_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_key_loader_mux4.sv
// Directed bench for key_loader_mux4: frame table plus corner sequences.
module tb_key_loader_mux4;

    logic clk = 1'b0;
    logic rst;
    logic key_sin;
    logic key_valid;
    logic abort;
    logic p1, p2, p3, p4;
    logic key_ready;
    logic load_err;
    logic locked_out;
    logic busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [4:0] frame;
        logic [3:0] p;
        logic       rdy;
        logic       err;
        logic       lock;
        logic       bsy;
    } vec_t;

    vec_t tv[12];

    key_loader_mux4 dut (
        .clk        (clk),
        .rst        (rst),
        .key_sin    (key_sin),
        .key_valid  (key_valid),
        .abort      (abort),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .key_ready  (key_ready),
        .load_err   (load_err),
        .locked_out (locked_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pk();
        return {p1, p2, p3, p4};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First bit is frame[4] (goes to p1), last is the parity bit.
    task automatic send_bits(input logic [4:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            key_valid = 1'b1;
            key_sin   = f[4-i];
            tick();
        end
        key_valid = 1'b0;
        key_sin   = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic [4:0] f,
                             input logic [3:0] p, input logic rdy,
                             input logic err, input logic lock,
                             input logic bsy);
        send_bits(f, 5);
        chk({nm, ".busy_chk"}, 32'(busy), 32'(bsy));
        tick();
        chk({nm, ".p"}, 32'(pk()), 32'(p));
        chk({nm, ".ready"}, 32'(key_ready), 32'(rdy));
        chk({nm, ".err"}, 32'(load_err), 32'(err));
        chk({nm, ".lock"}, 32'(locked_out), 32'(lock));
        tick();
        chk({nm, ".err_gone"}, 32'(load_err), 32'(0));
        chk({nm, ".busy_idle"}, 32'(busy), 32'(0));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".p"}, 32'(pk()), 32'(0));
        chk({nm, ".ready"}, 32'(key_ready), 32'(0));
        chk({nm, ".err"}, 32'(load_err), 32'(0));
        chk({nm, ".lock"}, 32'(locked_out), 32'(0));
        chk({nm, ".busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        tv[0]  = '{"good10111", 5'b10111, 4'b1011, 1, 0, 0, 1};
        tv[1]  = '{"bad10110",  5'b10110, 4'b1011, 0, 1, 0, 1};
        tv[2]  = '{"good01100", 5'b01100, 4'b0110, 1, 0, 0, 1};
        tv[3]  = '{"bad_a",     5'b10110, 4'b0110, 0, 1, 0, 1};
        tv[4]  = '{"bad_b",     5'b00001, 4'b0110, 0, 1, 0, 1};
        tv[5]  = '{"clr01100",  5'b01100, 4'b0110, 1, 0, 0, 1};
        tv[6]  = '{"bad_c",     5'b10110, 4'b0110, 0, 1, 0, 1};
        tv[7]  = '{"good11000", 5'b11000, 4'b1100, 1, 0, 0, 1};
        tv[8]  = '{"lk_bad1",   5'b10110, 4'b1100, 0, 1, 0, 1};
        tv[9]  = '{"lk_bad2",   5'b10110, 4'b1100, 0, 1, 0, 1};
        tv[10] = '{"lk_bad3",   5'b10110, 4'b0000, 0, 1, 1, 1};
        tv[11] = '{"lk_ign",    5'b01001, 4'b0000, 0, 0, 1, 0};

        rst       = 1'b1;
        key_sin   = 1'b0;
        key_valid = 1'b0;
        abort     = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");

        // First accepted bit in the first cycle with rst low.
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run_frame(tv[i].name, tv[i].frame, tv[i].p, tv[i].rdy,
                      tv[i].err, tv[i].lock, tv[i].bsy);
        end

        rst = 1'b1;
        tick();
        chk_all_zero("rst_lockout");
        rst = 1'b0;
        run_frame("after_rst", 5'b10111, 4'b1011, 1, 0, 0, 1);

        // Abort together with key_valid after three bits.
        send_bits(5'b11100, 3);
        key_valid = 1'b1;
        abort     = 1'b1;
        key_sin   = 1'b1;
        tick();
        key_valid = 1'b0;
        abort     = 1'b0;
        chk("abort.busy", 32'(busy), 32'(0));
        chk("abort.ready", 32'(key_ready), 32'(0));
        chk("abort.p", 32'(pk()), 32'(4'b1011));
        tick();
        chk("abort.hold", 32'(busy), 32'(0));
        run_frame("post_abort", 5'b11000, 4'b1100, 1, 0, 0, 1);

        // Gaps in key_valid, then key_valid held through CHECK.
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1;
            key_sin   = (5'b01100 >> (4 - i)) & 1'b1;
            tick();
            key_valid = 1'b0;
            tick();
            tick();
            if (i < 4) chk("gap.busy", 32'(busy), 32'(1));
        end
        chk("gap.p", 32'(pk()), 32'(4'b0110));
        chk("gap.ready", 32'(key_ready), 32'(1));
        send_bits(5'b10111, 5);
        key_valid = 1'b1;
        key_sin   = 1'b1;
        tick();
        key_valid = 1'b0;
        chk("vchk.p", 32'(pk()), 32'(4'b1011));
        chk("vchk.busy", 32'(busy), 32'(0));

        // Reset mid-frame.
        send_bits(5'b11000, 2);
        rst       = 1'b1;
        key_valid = 1'b1;
        tick();
        rst       = 1'b0;
        key_valid = 1'b0;
        chk_all_zero("rst_mid");
        run_frame("after_mid", 5'b10111, 4'b1011, 1, 0, 0, 1);

        // Abort must not clear the fail count: third bad frame locks.
        run_frame("fc_bad1", 5'b10110, 4'b1011, 0, 1, 0, 1);
        run_frame("fc_bad2", 5'b10110, 4'b1011, 0, 1, 0, 1);
        send_bits(5'b01100, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_frame("fc_bad3", 5'b10110, 4'b0000, 0, 1, 1, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("lock_abort", 32'(locked_out), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
